aes_inv_cipher_iter: RTL and testbench

Iterative AES inverse cipher (FIPS-197 InvCipher). It processes one round per clock and is the decrypt-direction counterpart of the encrypt path. It consumes the full expanded key schedule produced by KeyExpansion (bit 0 = MSB of word 0) and a 128-bit ciphertext, and returns the plaintext with a valid/ready handshake. It sits beside the encrypt core in the aes top level and shares the key schedule bus with it.

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_inv_round.sv | 47 ++++
 rtl/aes_inv_cipher_iter.sv | 109 ++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) helpers, inverse S-box and round-key slicing.
// Latency: none, purely combinational functions and constants.
// Backpressure: not applicable; this package holds no state.
package aes_pkg;

    localparam int NB          = 4;
    // Widest expanded schedule (AES-256, 15 round keys).
    localparam int SCHED_MAX_W = 128 * 15;

    // Bit 0 is the MSB of byte 0, matching the FIPS-197 byte order on the bus.
    typedef logic [0:127] state_t;
    typedef logic [0:31]  word_t;
    typedef logic [0:7]   byte_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } fsm_e;

    // Inverse S-box, entry n lives at bits [8n +: 8].
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb, 128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e, 128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692, 128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506, 128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673, 128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b, 128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f, 128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961, 128'h172b047e_ba77d626_e1691463_55210c7d
    };

    function automatic byte_t xtime(input byte_t b);
        logic [7:0] v;
        v = b;
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (0e/0b/0d/09 are all that InvMixColumns needs).
    function automatic byte_t gf_mul(input byte_t b, input logic [3:0] c);
        byte_t acc;
        byte_t t;
        acc = '0;
        t   = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) acc = acc ^ t;
            t = xtime(t);
        end
        return acc;
    endfunction

    function automatic byte_t inv_sbox(input byte_t b);
        return INV_SBOX[8*int'(b) +: 8];
    endfunction

    function automatic state_t round_key(input logic [0:SCHED_MAX_W-1] sched, input int r);
        return sched[128*r +: 128];
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
// Latency: combinational, result available in the same cycle.
// Backpressure: none; the caller owns all sequencing.
// Ports: state_i current state, rk_i round key, last_i skips InvMixColumns, state_o next state.
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t state_i,
    input  state_t rk_i,
    input  logic   last_i,
    output state_t state_o
);

    byte_t  sb [16];
    byte_t  ak [16];
    byte_t  mc [16];
    state_t nxt;

    always_comb begin
        // Row r rotates right by r: output column c takes input column (c - r) mod 4.
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NB; c++) begin
                sb[r + 4*c] = inv_sbox(state_i[8*(r + 4*((c + 4 - r) % 4)) +: 8]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            ak[i] = sb[i] ^ rk_i[8*i +: 8];
        end
        for (int c = 0; c < NB; c++) begin
            mc[4*c]   = gf_mul(ak[4*c], 4'he) ^ gf_mul(ak[4*c+1], 4'hb)
                      ^ gf_mul(ak[4*c+2], 4'hd) ^ gf_mul(ak[4*c+3], 4'h9);
            mc[4*c+1] = gf_mul(ak[4*c], 4'h9) ^ gf_mul(ak[4*c+1], 4'he)
                      ^ gf_mul(ak[4*c+2], 4'hb) ^ gf_mul(ak[4*c+3], 4'hd);
            mc[4*c+2] = gf_mul(ak[4*c], 4'hd) ^ gf_mul(ak[4*c+1], 4'h9)
                      ^ gf_mul(ak[4*c+2], 4'he) ^ gf_mul(ak[4*c+3], 4'hb);
            mc[4*c+3] = gf_mul(ak[4*c], 4'hb) ^ gf_mul(ak[4*c+1], 4'hd)
                      ^ gf_mul(ak[4*c+2], 4'h9) ^ gf_mul(ak[4*c+3], 4'he);
        end
        nxt = '0;
        for (int i = 0; i < 16; i++) begin
            nxt[8*i +: 8] = last_i ? ak[i] : mc[i];
        end
    end

    assign state_o = nxt;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, valid/ready on both sides.
// Latency: plaintext valid NR cycles after the accept edge; one block per NR+2 cycles at best.
// Backpressure: result held in DONE until out_ready; no new block accepted until then.
// Ports: clk/rst (sync, active high); in_valid/in_ready/ct/key_d input side;
//        out_valid/out_ready/pt output side; busy high while a block is in flight or held.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:127]          ct,
    input  logic [0:128*(NR+1)-1] key_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:127]          pt,
    output logic                  busy
);

    localparam int RW = $clog2(NR);

    if (NR != NK + 6) begin : g_bad_cfg
        $error("aes_inv_cipher_iter: NR must equal NK+6");
    end

    fsm_e            fsm_q, fsm_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    state_t          st_q, st_d;
    state_t          pt_q, pt_d;
    logic [0:SCHED_MAX_W-1] sched;
    state_t          rk_cur;
    state_t          rk_first;
    state_t          round_out;
    logic            last_rnd;

    // Pad the schedule to the widest size so one slice helper serves every key length.
    always_comb begin
        sched = '0;
        sched[0:128*(NR+1)-1] = key_d;
    end

    assign rk_first = round_key(sched, NR);
    assign rk_cur   = round_key(sched, int'(rnd_q));
    assign last_rnd = (rnd_q == '0);

    aes_inv_round u_round (
        .state_i (st_q),
        .rk_i    (rk_cur),
        .last_i  (last_rnd),
        .state_o (round_out)
    );

    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        st_d      = st_q;
        pt_d      = pt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (fsm_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    st_d  = ct ^ rk_first;
                    rnd_d = RW'(NR - 1);
                    fsm_d = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                st_d = round_out;
                if (last_rnd) begin
                    pt_d  = round_out;
                    fsm_d = S_DONE;
                end else begin
                    rnd_d = rnd_q - 1'b1;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q <= S_IDLE;
            rnd_q <= '0;
            st_q  <= '0;
            pt_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            rnd_q <= rnd_d;
            st_q  <= st_d;
            pt_q  <= pt_d;
        end
    end

    assign pt = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for the iterative AES inverse cipher at all three key lengths.
// Reference: a forward AES model built from GF(2^8) arithmetic; the DUT must invert it.
// Drives inputs #1 after the rising edge and samples outputs at the same point.
module tb_aes_inv_cipher_iter;

    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [2:0]        in_valid;
    logic [2:0]        out_ready;
    wire  [2:0]        in_ready;
    wire  [2:0]        out_valid;
    wire  [2:0]        busy;
    logic [0:127]      ct [3];
    wire  [0:127]      pt0, pt1, pt2;
    logic [0:128*11-1] key4;
    logic [0:128*13-1] key6;
    logic [0:128*15-1] key8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  sbox [256];
    logic [31:0] w [60];

    aes_inv_cipher_iter #(.NK(4), .NR(10)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .ct(ct[0]),
        .key_d(key4), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .pt(pt0), .busy(busy[0]));
    aes_inv_cipher_iter #(.NK(6), .NR(12)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .ct(ct[1]),
        .key_d(key6), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .pt(pt1), .busy(busy[1]));
    aes_inv_cipher_iter #(.NK(8), .NR(14)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .ct(ct[2]),
        .key_d(key8), .out_valid(out_valid[2]), .out_ready(out_ready[2]), .pt(pt2), .busy(busy[2]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nk+7); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] p, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int rw = 0; rw < 4; rw++)
                for (int c = 0; c < 4; c++) t[rw+4*c] = s[rw+4*((c+rw)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r != nr) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic load_key(input int k, input logic [255:0] key);
        expand(key, 4 + 2*k);
        for (int i = 0; i < 4*(11 + 2*k); i++) begin
            if (k == 0)      key4[32*i +: 32] = w[i];
            else if (k == 1) key6[32*i +: 32] = w[i];
            else             key8[32*i +: 32] = w[i];
        end
    endtask

    function automatic logic [127:0] get_pt(input int k);
        return (k == 0) ? pt0 : (k == 1) ? pt1 : pt2;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Offer one block, return the plaintext and cycles from the accept edge to out_valid.
    task automatic run_block(input int k, input logic [127:0] c, output logic [127:0] p, output int lat);
        ct[k]       = c;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1 in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        p = get_pt(k);
    endtask

    task automatic handshake(input int k);
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1 out_ready[k] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0 || get_pt(k) !== 128'h0) begin
                n_fail++;
                $display("FAIL reset k=%0d: out_valid=%b in_ready=%b busy=%b pt=%h, want 0 1 0 0",
                         k, out_valid[k], in_ready[k], busy[k], get_pt(k));
            end
        end
    endtask

    task automatic test_kat();
        logic [255:0] kv [4];
        logic [127:0] cv [4];
        logic [127:0] pv [4];
        int           kk [4];
        logic [127:0] p;
        int           lat;
        kv[0] = KEY_B;  cv[0] = CT_B;  pv[0] = PT_B; kk[0] = 0;
        kv[1] = KEY_C1; cv[1] = CT_C1; pv[1] = PT_C; kk[1] = 0;
        kv[2] = KEY_C2; cv[2] = CT_C2; pv[2] = PT_C; kk[2] = 1;
        kv[3] = KEY_C3; cv[3] = CT_C3; pv[3] = PT_C; kk[3] = 2;
        for (int n = 0; n < 4; n++) begin
            load_key(kk[n], kv[n]);
            run_block(kk[n], cv[n], p, lat);
            n_checks++;
            if (p !== pv[n]) begin
                n_fail++;
                $display("FAIL kat%0d_pt: got %h want %h", n, p, pv[n]);
            end
            n_checks++;
            if (lat != 10 + 2*kk[n]) begin
                n_fail++;
                $display("FAIL kat%0d_latency: got %0d want %0d", n, lat, 10 + 2*kk[n]);
            end
            handshake(kk[n]);
        end
    endtask

    task automatic test_random();
        logic [127:0] p, c, got;
        int           lat;
        int           k;
        for (int n = 0; n < 6; n++) begin
            k = n % 3;
            load_key(k, {rand128(), rand128()});
            p = rand128();
            c = encrypt(p, 10 + 2*k);
            run_block(k, c, got, lat);
            n_checks++;
            if (got !== p || lat != 10 + 2*k) begin
                n_fail++;
                $display("FAIL random%0d k=%0d: pt=%h lat=%0d want pt=%h lat=%0d", n, k, got, lat, p, 10 + 2*k);
            end
            handshake(k);
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] p;
        int           lat;
        load_key(0, KEY_B);
        ct[0]       = CT_B;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 ct[0] = ~CT_B;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_run_ready cyc=%0d: in_ready=%b busy=%b want 0 1", i, in_ready[0], busy[0]);
            end
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        lat = 3;
        while (!out_valid[0] && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        n_checks++;
        if (lat != 10 || get_pt(0) !== PT_B) begin
            n_fail++;
            $display("FAIL bp_first: lat=%0d pt=%h want 10 %h", lat, get_pt(0), PT_B);
        end
        ct[0]       = CT_B;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || get_pt(0) !== PT_B) begin
                n_fail++;
                $display("FAIL bp_hold cyc=%0d: out_valid=%b in_ready=%b pt=%h want 1 0 %h",
                         i, out_valid[0], in_ready[0], get_pt(0), PT_B);
            end
        end
        handshake(0);
        n_checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_retire: out_valid=%b in_ready=%b busy=%b want 0 1 0", out_valid[0], in_ready[0], busy[0]);
        end
        run_block(0, CT_B, p, lat);
        n_checks++;
        if (p !== PT_B || lat != 10) begin
            n_fail++;
            $display("FAIL bp_second: pt=%h lat=%0d want %h 10", p, lat, PT_B);
        end
        handshake(0);
    endtask

    task automatic test_back_to_back();
        logic [127:0] p, c;
        int           t0, t1;
        load_key(1, {rand128(), rand128()});
        p            = rand128();
        c            = encrypt(p, 12);
        ct[1]        = c;
        in_valid[1]  = 1'b1;
        out_ready[1] = 1'b1;
        t0 = -1;
        t1 = -1;
        for (int t = 0; t < 60 && t1 < 0; t++) begin
            @(posedge clk);
            #1;
            if (out_valid[1]) begin
                n_checks++;
                if (get_pt(1) !== p) begin
                    n_fail++;
                    $display("FAIL b2b_pt t=%0d: got %h want %h", t, get_pt(1), p);
                end
                if (t0 < 0) t0 = t;
                else        t1 = t;
            end
        end
        in_valid[1] = 1'b0;
        @(posedge clk);
        #1 out_ready[1] = 1'b0;
        n_checks++;
        if (t0 < 0 || t1 < 0 || t1 - t0 != 14) begin
            n_fail++;
            $display("FAIL b2b_period: got %0d want 14", t1 - t0);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] p;
        int           lat;
        load_key(0, KEY_C1);
        ct[0]       = CT_C1;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if (out_valid[0] !== 1'b0 || get_pt(0) !== 128'h0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst: out_valid=%b pt=%h in_ready=%b busy=%b want 0 0 1 0",
                     out_valid[0], get_pt(0), in_ready[0], busy[0]);
        end
        load_key(0, KEY_B);
        run_block(0, CT_B, p, lat);
        n_checks++;
        if (p !== PT_B || lat != 10) begin
            n_fail++;
            $display("FAIL midrst_after: pt=%h lat=%0d want %h 10", p, lat, PT_B);
        end
        handshake(0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 3'b000;
        out_ready = 3'b000;
        for (int k = 0; k < 3; k++) ct[k] = '0;
        key4 = '0;
        key6 = '0;
        key8 = '0;
        build_sbox();
        test_reset();
        test_kat();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
